ps2_host: RTL and testbench

PS2_HOST -- requirements
Module: ps2_host

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_sync.sv | 32 +++
 rtl/ps2_host.sv | 257 +++++++++++++++++++++++++
 tb/tb_ps2_host.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 host definitions: controller states, frame geometry and the
// odd-parity helper used by both the receive check and the transmit frame.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RX,
      TX_INH,
      TX_START,
      TX_BITS,
      TX_ACK,
      TX_WAIT
   } ps2_state_e;

   // start + 8 data + parity + stop (+ device ACK slot on transmit)
   localparam int FRAME_BITS = 11;

   // Bit that makes the ones-count over data+parity odd.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for one open-collector PS/2 line plus a falling-edge
// detector on the synchronized level; lines idle high, so reset loads ones.
module ps2_sync
   import ps2_pkg::*;
(
   input  logic clk_sys,
   input  logic reset,
   input  logic line,
   output logic level,
   output logic fall
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         meta <= 1'b1;
         sync <= 1'b1;
         prev <= 1'b1;
      end else begin
         meta <= line;
         sync <= meta;
         prev <= sync;
      end
   end

   assign level = sync;
   assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host.sv
// PS/2 host controller: receives device frames and, when PS2_HOST_TX_EN is
// defined, sends command bytes using the inhibit / request-to-send sequence.
module ps2_host
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYC = 2000,
   parameter int TIMEOUT_CYC = 40000
)
(
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_out,
   output logic       ps2_dat_out,
   output logic [7:0] rx_data,
   output logic       rx_strobe,
   output logic       rx_error,
   input  logic [7:0] tx_data,
   input  logic       tx_req,
   output logic       tx_busy,
   output logic       tx_ack,
   output logic       tx_err
);

   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam int IN_W = $clog2(INHIBIT_CYC + 1);
   // Edge index (0-based, after the start bit) carrying the stop bit.
   localparam logic [3:0] LAST_EDGE = 4'(FRAME_BITS - 2);

   logic clk_q;
   logic clk_fall;
   logic dat_q;
   logic dat_fall_unused;

   ps2_sync u_sync_clk (
      .clk_sys (clk_sys),
      .reset   (reset),
      .line    (ps2_clk_in),
      .level   (clk_q),
      .fall    (clk_fall)
   );

   ps2_sync u_sync_dat (
      .clk_sys (clk_sys),
      .reset   (reset),
      .line    (ps2_dat_in),
      .level   (dat_q),
      .fall    (dat_fall_unused)
   );

   ps2_state_e      state, state_n;
   logic [3:0]      bit_cnt, bit_cnt_n;
   logic [8:0]      rx_shift, rx_shift_n;
   logic [8:0]      tx_frame, tx_frame_n;
   logic [WD_W-1:0] wdog, wdog_n;
   logic [IN_W-1:0] inh_cnt, inh_cnt_n;
   logic [7:0]      rx_data_q, rx_data_n;
   logic            rx_strobe_q, rx_strobe_n;
   logic            rx_error_q, rx_error_n;
   logic            clk_out_q, clk_out_n;
   logic            dat_out_q, dat_out_n;
   logic            tx_busy_q, tx_busy_n;
   logic            tx_ack_q, tx_ack_n;
   logic            tx_err_q, tx_err_n;
   logic            wd_active;
   logic            timeout;

   // wdog holds the number of cycles elapsed since the cycle the edge was seen,
   // so the abort pulse lands exactly TIMEOUT_CYC cycles after that edge.
   assign wd_active = state inside {RX, TX_START, TX_BITS, TX_ACK};
   assign timeout   = wd_active && !clk_fall && (wdog == WD_W'(TIMEOUT_CYC - 1));

   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      rx_shift_n  = rx_shift;
      tx_frame_n  = tx_frame;
      inh_cnt_n   = inh_cnt;
      rx_data_n   = rx_data_q;
      rx_strobe_n = 1'b0;
      rx_error_n  = 1'b0;
      clk_out_n   = clk_out_q;
      dat_out_n   = dat_out_q;
      tx_busy_n   = tx_busy_q;
      tx_ack_n    = 1'b0;
      tx_err_n    = 1'b0;

      if (clk_fall) begin
         wdog_n = WD_W'(1);
      end else if (wd_active) begin
         wdog_n = wdog + WD_W'(1);
      end else begin
         wdog_n = '0;
      end

      if (timeout) begin
         state_n   = IDLE;
         clk_out_n = 1'b1;
         dat_out_n = 1'b1;
         if (state == RX) begin
            rx_error_n = 1'b1;
         end else begin
            tx_err_n  = 1'b1;
            tx_busy_n = 1'b0;
         end
      end else begin
         case (state)
            IDLE: begin
`ifdef PS2_HOST_TX_EN
               if (tx_req) begin
                  state_n    = TX_INH;
                  tx_frame_n = {odd_parity(tx_data), tx_data};
                  tx_busy_n  = 1'b1;
                  clk_out_n  = 1'b0;
                  dat_out_n  = 1'b1;
                  inh_cnt_n  = IN_W'(1);
               end else
`endif
               if (clk_fall && !dat_q) begin
                  state_n   = RX;
                  bit_cnt_n = 4'd0;
               end
            end

            RX: begin
               if (clk_fall) begin
                  if (bit_cnt == LAST_EDGE) begin
                     state_n = IDLE;
                     if (dat_q && (rx_shift[8] == odd_parity(rx_shift[7:0]))) begin
                        rx_data_n   = rx_shift[7:0];
                        rx_strobe_n = 1'b1;
                     end else begin
                        rx_error_n = 1'b1;
                     end
                  end else begin
                     // Data bits then parity arrive LSB first; parity ends up in bit 8.
                     rx_shift_n = {dat_q, rx_shift[8:1]};
                     bit_cnt_n  = bit_cnt + 4'd1;
                  end
               end
            end

`ifdef PS2_HOST_TX_EN
            TX_INH: begin
               // Data drops in the last inhibit cycle so the clock is low INHIBIT_CYC cycles.
               if (inh_cnt == IN_W'(INHIBIT_CYC - 1)) begin
                  state_n   = TX_START;
                  dat_out_n = 1'b0;
               end else begin
                  inh_cnt_n = inh_cnt + IN_W'(1);
               end
            end

            TX_START: begin
               clk_out_n = 1'b1;
               bit_cnt_n = 4'd0;
               state_n   = TX_BITS;
            end

            TX_BITS: begin
               if (clk_fall) begin
                  // Ones shift in behind the frame, so edge 10 drives the stop/release level.
                  dat_out_n  = tx_frame[0];
                  tx_frame_n = {1'b1, tx_frame[8:1]};
                  if (bit_cnt == LAST_EDGE) begin
                     state_n = TX_ACK;
                  end else begin
                     bit_cnt_n = bit_cnt + 4'd1;
                  end
               end
            end

            TX_ACK: begin
               if (clk_fall) begin
                  if (!dat_q) begin
                     tx_ack_n = 1'b1;
                  end else begin
                     tx_err_n = 1'b1;
                  end
                  state_n = TX_WAIT;
               end
            end

            TX_WAIT: begin
               if (clk_q && dat_q) begin
                  state_n   = IDLE;
                  tx_busy_n = 1'b0;
               end
            end
`endif

            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state       <= IDLE;
         bit_cnt     <= 4'd0;
         rx_shift    <= 9'd0;
         tx_frame    <= 9'd0;
         wdog        <= '0;
         inh_cnt     <= '0;
         rx_data_q   <= 8'h00;
         rx_strobe_q <= 1'b0;
         rx_error_q  <= 1'b0;
         clk_out_q   <= 1'b1;
         dat_out_q   <= 1'b1;
         tx_busy_q   <= 1'b0;
         tx_ack_q    <= 1'b0;
         tx_err_q    <= 1'b0;
      end else begin
         state       <= state_n;
         bit_cnt     <= bit_cnt_n;
         rx_shift    <= rx_shift_n;
         tx_frame    <= tx_frame_n;
         wdog        <= wdog_n;
         inh_cnt     <= inh_cnt_n;
         rx_data_q   <= rx_data_n;
         rx_strobe_q <= rx_strobe_n;
         rx_error_q  <= rx_error_n;
         clk_out_q   <= clk_out_n;
         dat_out_q   <= dat_out_n;
         tx_busy_q   <= tx_busy_n;
         tx_ack_q    <= tx_ack_n;
         tx_err_q    <= tx_err_n;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_strobe = rx_strobe_q;
   assign rx_error  = rx_error_q;

`ifdef PS2_HOST_TX_EN
   assign ps2_clk_out = clk_out_q;
   assign ps2_dat_out = dat_out_q;
   assign tx_busy     = tx_busy_q;
   assign tx_ack      = tx_ack_q;
   assign tx_err      = tx_err_q;
`else
   // Receive-only build: the host never drives the bus.
   logic unused_tx;
   assign unused_tx = ^{tx_req, tx_data, clk_q, clk_out_q, dat_out_q,
                        tx_busy_q, tx_ack_q, tx_err_q, tx_frame, inh_cnt};

   assign ps2_clk_out = 1'b1;
   assign ps2_dat_out = 1'b1;
   assign tx_busy     = 1'b0;
   assign tx_ack      = 1'b0;
   assign tx_err      = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host.sv
// Directed bench for ps2_host: a PS/2 device model on wired-AND lines, received
// bytes scored against an expected queue, transmit checks when PS2_HOST_TX_EN is set.
module tb_ps2_host;

   localparam int INHIBIT = 2000;
   localparam int TIMEOUT = 4000;
   localparam int HALF    = 20;

   logic       clk_sys = 1'b0;
   logic       reset   = 1'b1;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_req  = 1'b0;
   logic       ps2_clk_in, ps2_dat_in;
   logic       ps2_clk_out, ps2_dat_out;
   logic [7:0] rx_data;
   logic       rx_strobe, rx_error, tx_busy, tx_ack, tx_err;

   assign ps2_clk_in = ps2_clk_out & dev_clk;
   assign ps2_dat_in = ps2_dat_out & dev_dat;

   ps2_host #(.INHIBIT_CYC(INHIBIT), .TIMEOUT_CYC(TIMEOUT)) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_dat_in  (ps2_dat_in),
      .ps2_clk_out (ps2_clk_out),
      .ps2_dat_out (ps2_dat_out),
      .rx_data     (rx_data),
      .rx_strobe   (rx_strobe),
      .rx_error    (rx_error),
      .tx_data     (tx_data),
      .tx_req      (tx_req),
      .tx_busy     (tx_busy),
      .tx_ack      (tx_ack),
      .tx_err      (tx_err)
   );

   // ---------------- clock / time limit ----------------
   always #5 clk_sys = ~clk_sys;

   initial begin
      #2ms;
      $display("FAIL time_limit: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "time limit");
   end

   // ---------------- scoreboard / event counters ----------------
   int         n_checks = 0;
   int         n_fail = 0;
   int         n_rx_strobe = 0, n_rx_error = 0, n_tx_ack = 0, n_tx_err = 0, n_overlap = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic [7:0] last_good = 8'h00;

   // One sample per cycle on the falling clk_sys edge, away from the active edge.
   task automatic tick();
      @(negedge clk_sys);
      if (rx_strobe) begin
         n_rx_strobe++;
         got_q.push_back(rx_data);
      end
      if (rx_error) n_rx_error++;
      if (tx_ack)   n_tx_ack++;
      if (tx_err)   n_tx_err++;
      if ((rx_strobe && rx_error) || (tx_ack && tx_err)) n_overlap++;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   // ---------------- device driver tasks ----------------
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int n_edges);
      logic [10:0] f;
      f = {stop, par, d, 1'b0};
      for (int i = 0; i < n_edges; i++) begin
         dev_dat = f[i];
         ticks(HALF);
         dev_clk = 1'b0;
         ticks(HALF);
         dev_clk = 1'b1;
      end
      dev_dat = 1'b1;
   endtask

   // Host-to-device transfer as seen by the device: waits out the inhibit,
   // then clocks 11 edges, sampling the host data before each rising edge.
   task automatic device_tx(input logic ack_bit, output int low_cnt, output logic dat_at_release,
                            output logic [9:0] bits, output logic busy_at_ack);
      low_cnt = 0;
      bits = '0;
      busy_at_ack = 1'b0;
      tick();
      tx_req = 1'b0;
      while (ps2_clk_out === 1'b0 && low_cnt < 3 * INHIBIT) begin
         low_cnt++;
         tick();
      end
      dat_at_release = ps2_dat_out;
      for (int i = 0; i < 11; i++) begin
         if (i == 10) dev_dat = ack_bit;
         ticks(HALF);
         dev_clk = 1'b0;
         ticks(HALF);
         if (i < 10) bits[i] = ps2_dat_out;
         else        busy_at_ack = tx_busy;
         dev_clk = 1'b1;
      end
      ticks(HALF);
      dev_dat = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      ticks(5);
      n_checks++;
      if ({ps2_clk_out, ps2_dat_out} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_lines: got %b, expected 11", {ps2_clk_out, ps2_dat_out});
      end
      n_checks++;
      if (rx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_rx_data: got %02h, expected 00", rx_data);
      end
      n_checks++;
      if ({rx_strobe, rx_error, tx_busy, tx_ack, tx_err} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b, expected 00000", {rx_strobe, rx_error, tx_busy, tx_ack, tx_err});
      end
      reset = 1'b0;
      ticks(5);
   endtask

   task automatic test_rx_good();
      int s0, e0;
      logic [7:0] exp, got;
      s0 = n_rx_strobe;
      e0 = n_rx_error;
      exp_q.push_back(8'h1C);
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      ticks(HALF);
      last_good = 8'h1C;
      n_checks++;
      if (n_rx_strobe - s0 != 1 || n_rx_error - e0 != 0) begin
         n_fail++;
         $display("FAIL rx_good_pulses: got strobes=%0d errors=%0d, expected 1 and 0", n_rx_strobe - s0, n_rx_error - e0);
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin
         n_fail++;
         $display("FAIL rx_good_data: got no byte, expected %02h", exp);
      end else begin
         got = got_q.pop_front();
         if (got !== exp) begin
            n_fail++;
            $display("FAIL rx_good_data: got %02h, expected %02h", got, exp);
         end
      end
   endtask

   task automatic test_rx_bad(input string name, input logic [7:0] d, input logic par, input logic stop);
      int s0, e0;
      s0 = n_rx_strobe;
      e0 = n_rx_error;
      send_frame(d, par, stop, 11);
      ticks(HALF);
      n_checks++;
      if (n_rx_error - e0 != 1 || n_rx_strobe - s0 != 0) begin
         n_fail++;
         $display("FAIL %s_pulses: got errors=%0d strobes=%0d, expected 1 and 0", name, n_rx_error - e0, n_rx_strobe - s0);
      end
      n_checks++;
      if (rx_data !== last_good) begin
         n_fail++;
         $display("FAIL %s_data: got %02h, expected unchanged %02h", name, rx_data, last_good);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d, exp, got;
      int e0;
      e0 = n_rx_error;
      for (int k = 0; k < 4; k++) begin
         d = 8'($urandom_range(0, 255));
         exp_q.push_back(d);
         send_frame(d, ~^d, 1'b1, 11);
         last_good = d;
         ticks($urandom_range(2, 30));
      end
      ticks(HALF);
      n_checks++;
      if (got_q.size() != exp_q.size() || n_rx_error != e0) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d bytes %0d errors, expected %0d bytes 0 errors",
                  got_q.size(), n_rx_error - e0, exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         exp = exp_q.pop_front();
         got = got_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL b2b_data: got %02h, expected %02h", got, exp);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   // The edge reaches the controller after two synchronizer flops, then the
   // error pulse is due TIMEOUT cycles later.
   task automatic test_timeout();
      int s0, e0, err_at;
      logic [7:0] d;
      d = 8'hA5;
      s0 = n_rx_strobe;
      e0 = n_rx_error;
      send_frame(d, ~^d, 1'b1, 4);
      dev_dat = d[3];
      ticks(HALF);
      dev_clk = 1'b0;
      err_at = 0;
      for (int n = 1; n <= TIMEOUT + 50; n++) begin
         tick();
         if (n == HALF) dev_clk = 1'b1;
         if (rx_error && err_at == 0) err_at = n;
      end
      dev_dat = 1'b1;
      n_checks++;
      if (err_at != TIMEOUT + 2) begin
         n_fail++;
         $display("FAIL timeout_latency: got rx_error at cycle %0d, expected %0d", err_at, TIMEOUT + 2);
      end
      n_checks++;
      if (n_rx_error - e0 != 1 || n_rx_strobe - s0 != 0) begin
         n_fail++;
         $display("FAIL timeout_pulses: got errors=%0d strobes=%0d, expected 1 and 0", n_rx_error - e0, n_rx_strobe - s0);
      end
      n_checks++;
      if (rx_data !== last_good) begin
         n_fail++;
         $display("FAIL timeout_data: got %02h, expected unchanged %02h", rx_data, last_good);
      end
   endtask

`ifdef PS2_HOST_TX_EN
   task automatic test_tx(input string name, input logic [7:0] d, input logic ack_bit);
      int a0, x0, s0, e0, low_cnt, guard;
      logic dat_rel, busy_ack;
      logic [9:0] bits, exp_bits;
      a0 = n_tx_ack; x0 = n_tx_err; s0 = n_rx_strobe; e0 = n_rx_error;
      exp_bits = {1'b1, ~^d, d};
      tx_data = d;
      tx_req = 1'b1;
      device_tx(ack_bit, low_cnt, dat_rel, bits, busy_ack);
      guard = 0;
      while (tx_busy !== 1'b0 && guard < 100) begin
         guard++;
         tick();
      end
      n_checks++;
      if (low_cnt != INHIBIT || dat_rel !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_inhibit: got clk low %0d cycles data %b at release, expected %0d and 0", name, low_cnt, dat_rel, INHIBIT);
      end
      n_checks++;
      if (bits !== exp_bits) begin
         n_fail++;
         $display("FAIL %s_bits: got %b, expected %b (stop,parity,data)", name, bits, exp_bits);
      end
      n_checks++;
      if (n_tx_ack - a0 != (ack_bit ? 0 : 1) || n_tx_err - x0 != (ack_bit ? 1 : 0)) begin
         n_fail++;
         $display("FAIL %s_result: got ack=%0d err=%0d, expected ack=%0d err=%0d",
                  name, n_tx_ack - a0, n_tx_err - x0, ack_bit ? 0 : 1, ack_bit ? 1 : 0);
      end
      n_checks++;
      if (busy_ack !== 1'b1 || tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_busy: got %b during ack, %b after idle, expected 1 then 0", name, busy_ack, tx_busy);
      end
      n_checks++;
      if (n_rx_strobe != s0 || n_rx_error != e0 || got_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_no_rx: got strobes=%0d errors=%0d, expected 0 and 0", name, n_rx_strobe - s0, n_rx_error - e0);
      end
      got_q.delete();
   endtask

   task automatic test_reset_mid_tx();
      int guard, c0;
      logic dat_before, busy_before;
      tx_data = 8'hED;
      tx_req = 1'b1;
      tick();
      tx_req = 1'b0;
      guard = 0;
      while (ps2_clk_out !== 1'b1 && guard < 3 * INHIBIT) begin
         guard++;
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         ticks(HALF);
         dev_clk = 1'b0;
         ticks(HALF);
         dev_clk = 1'b1;
      end
      dat_before = ps2_dat_out;
      busy_before = tx_busy;
      n_checks++;
      if (dat_before !== 1'b0 || busy_before !== 1'b1) begin
         n_fail++;
         $display("FAIL midtx_before: got data %b busy %b, expected 0 and 1", dat_before, busy_before);
      end
      c0 = n_rx_strobe + n_rx_error + n_tx_ack + n_tx_err;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if ({ps2_clk_out, ps2_dat_out, tx_busy} !== 3'b110) begin
         n_fail++;
         $display("FAIL midtx_release: got clk,dat,busy=%b, expected 110", {ps2_clk_out, ps2_dat_out, tx_busy});
      end
      ticks(4 * HALF);
      last_good = 8'h00;
      n_checks++;
      if (n_rx_strobe + n_rx_error + n_tx_ack + n_tx_err != c0 || rx_data !== last_good) begin
         n_fail++;
         $display("FAIL midtx_quiet: got %0d pulses rx_data %02h, expected 0 pulses rx_data 00",
                  n_rx_strobe + n_rx_error + n_tx_ack + n_tx_err - c0, rx_data);
      end
   endtask
`else
   task automatic test_tx_disabled();
      int bad_lines, bad_tx, s0;
      logic [7:0] exp, got;
      bad_lines = 0;
      bad_tx = 0;
      tx_data = 8'hED;
      tx_req = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (ps2_clk_out !== 1'b1 || ps2_dat_out !== 1'b1) bad_lines++;
         if (tx_busy !== 1'b0 || tx_ack !== 1'b0 || tx_err !== 1'b0) bad_tx++;
      end
      n_checks++;
      if (bad_lines != 0 || bad_tx != 0) begin
         n_fail++;
         $display("FAIL txoff_idle: got %0d line and %0d tx-flag cycles active, expected 0 and 0", bad_lines, bad_tx);
      end
      s0 = n_rx_strobe;
      exp_q.push_back(8'h3A);
      send_frame(8'h3A, ~^8'h3A, 1'b1, 11);
      ticks(HALF);
      tx_req = 1'b0;
      last_good = 8'h3A;
      exp = exp_q.pop_front();
      n_checks++;
      if (n_rx_strobe - s0 != 1 || got_q.size() == 0) begin
         n_fail++;
         $display("FAIL txoff_rx: got %0d strobes, expected 1 byte %02h", n_rx_strobe - s0, exp);
      end else begin
         got = got_q.pop_front();
         if (got !== exp) begin
            n_fail++;
            $display("FAIL txoff_rx: got %02h, expected %02h", got, exp);
         end
      end
      got_q.delete();
   endtask
`endif

   // ---------------- sequence / report ----------------
   initial begin
      test_reset();
      test_rx_good();
      test_rx_bad("rx_parity", 8'h1C, 1'b1, 1'b1);
      test_rx_bad("rx_stop", 8'h55, ~^8'h55, 1'b0);
      test_back_to_back();
      test_timeout();
`ifdef PS2_HOST_TX_EN
      test_tx("tx_ack", 8'hED, 1'b0);
      test_tx("tx_noack", 8'hF4, 1'b1);
      test_reset_mid_tx();
`else
      test_tx_disabled();
`endif
      n_checks++;
      if (n_overlap != 0) begin
         n_fail++;
         $display("FAIL strobe_overlap: got %0d overlapping cycles, expected 0", n_overlap);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
